// File: rtl/uart_rx.sv
// UART receiver: 8N1. Bit period is (div+1) clocks. The line passes through a
// two-flop synchroniser and a glitch filter, and every bit is sampled mid-bit.
module uart_rx #(
  parameter int DIV_WIDTH     = 8,
  parameter int GLITCH_FILTER = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [7:0]           data,
  output logic                 stb
);
  logic [1:0]               sync;
  logic [GLITCH_FILTER-1:0] hist;
  logic                     filt;
  logic                     active;
  logic [DIV_WIDTH-1:0]     tick;
  logic [3:0]               bitn;
  logic [7:0]               sh;

  // Synchronise the line; the filtered level only changes after GLITCH_FILTER equal samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      hist <= '1;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], rx};
      hist <= GLITCH_FILTER'({hist, sync[1]});
      if (&hist)       filt <= 1'b1;
      else if (~|hist) filt <= 1'b0;
    end
  end

  // Frame receiver: half a bit to the centre of the start bit, then one full bit per sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      tick   <= '0;
      bitn   <= '0;
      sh     <= '0;
      data   <= '0;
      stb    <= 1'b0;
    end else begin
      stb <= 1'b0;
      if (!active) begin
        if (!filt) begin
          active <= 1'b1;
          tick   <= div >> 1;
          bitn   <= '0;
        end
      end else if (tick != '0) begin
        tick <= tick - 1'b1;
      end else begin
        tick <= div;
        bitn <= bitn + 1'b1;
        if (bitn == 4'd0) begin
          // A start bit that is high again at its centre was a glitch
          if (filt) active <= 1'b0;
        end else if (bitn <= 4'd8) begin
          sh <= {filt, sh[7:1]};
        end else begin
          active <= 1'b0;
          if (filt) begin
            data <= sh;
            stb  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, bit period (div+1) clocks. Valid/ready: the byte on
// data is taken when valid is seen while idle, and valid must stay high until
// ack; ack pulses for one cycle at the end of the stop bit.
module uart_tx #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data,
  input  logic                 valid,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tx,
  output logic                 ack
);
  logic                 active;
  logic [DIV_WIDTH-1:0] tick;
  logic [3:0]           left;
  logic [8:0]           sh;

  assign ack = active && (tick >= div) && (left == 4'd0);

  // Shift out start, 8 data bits LSB first, then stop; the line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      tick   <= '0;
      left   <= '0;
      sh     <= '1;
      tx     <= 1'b1;
    end else if (!active) begin
      if (valid) begin
        active <= 1'b1;
        tx     <= 1'b0;
        sh     <= {1'b1, data};
        left   <= 4'd9;
        tick   <= '0;
      end
    end else if (tick < div) begin
      tick <= tick + 1'b1;
    end else begin
      tick <= '0;
      if (left == 4'd0) begin
        active <= 1'b0;
      end else begin
        tx   <= sh[0];
        sh   <= {1'b1, sh[8:1]};
        left <= left - 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug initiator: decodes read/write command frames from the
// host, runs one classic Wishbone cycle, and answers with a status byte plus
// read data.
module uart_wb_bridge #(
  parameter int DIV_WIDTH = 8,
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int TO_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DIV_WIDTH-1:0] uart_div,
  output logic [AW-1:0]        wb_addr,
  output logic [DW-1:0]        wb_wdata,
  input  logic [DW-1:0]        wb_rdata,
  output logic                 wb_we,
  output logic                 wb_cyc,
  input  logic                 wb_ack,
  output logic                 busy,
  output logic                 rx_drop
);
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  // Last count value before the bus is abandoned (2^TO_W-1 cycles of wb_cyc)
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_STAT, S_RDATA} state_t;

  state_t          state, state_d;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_stb;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ack;
  logic            is_wr;
  logic [7:0]      cnt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      status;
  logic [DW-1:0]   rdata_q;
  logic [AW+7:0]   addr_cat;
  logic [DW+7:0]   wdata_cat;
  logic            rsp_phase;

  assign rst       = ~rst_n;
  assign addr_cat  = {wb_addr, rx_data};
  assign wdata_cat = {wb_wdata, rx_data};
  assign rsp_phase = (state == S_BUS) || (state == S_STAT) || (state == S_RDATA);

  uart_rx #(.DIV_WIDTH(DIV_WIDTH), .GLITCH_FILTER(2)) u_rx (
    .clk(clk), .rst(rst), .rx(uart_rx), .div(uart_div), .data(rx_data), .stb(rx_stb)
  );

  uart_tx #(.DIV_WIDTH(DIV_WIDTH)) u_tx (
    .clk(clk), .rst(rst), .data(tx_data), .valid(tx_valid), .div(uart_div),
    .tx(uart_tx), .ack(tx_ack)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and TX byte selection; valid only in STAT/RDATA
  always_comb begin
    state_d  = state;
    tx_valid = 1'b0;
    tx_data  = status;
    case (state)
      S_IDLE:  if (rx_stb && (rx_data == 8'h01 || rx_data == 8'h02)) state_d = S_ADDR;
      S_ADDR:  if (rx_stb && cnt == 8'(AB - 1)) state_d = is_wr ? S_WDATA : S_BUS;
      S_WDATA: if (rx_stb && cnt == 8'(DB - 1)) state_d = S_BUS;
      S_BUS:   if (wb_ack || to_cnt == TO_LAST) state_d = S_STAT;
      S_STAT: begin
        tx_valid = 1'b1;
        tx_data  = status;
        if (tx_ack) state_d = (!is_wr && status == 8'h00) ? S_RDATA : S_IDLE;
      end
      S_RDATA: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[DW-1 -: 8];
        if (tx_ack && cnt == 8'(DB - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame capture, bus cycle control, response sequencing and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr  <= '0;
      wb_wdata <= '0;
      wb_we    <= 1'b0;
      wb_cyc   <= 1'b0;
      busy     <= 1'b0;
      rx_drop  <= 1'b0;
      is_wr    <= 1'b0;
      cnt      <= '0;
      to_cnt   <= '0;
      status   <= '0;
      rdata_q  <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      if (rx_stb && rsp_phase) rx_drop <= 1'b1;
      case (state)
        S_IDLE: begin
          if (state_d == S_ADDR) begin
            is_wr <= (rx_data == 8'h02);
            cnt   <= '0;
          end
        end
        S_ADDR: begin
          if (rx_stb) begin
            wb_addr <= addr_cat[AW-1:0];
            cnt     <= (state_d == S_ADDR) ? cnt + 1'b1 : 8'd0;
          end
          if (state_d == S_BUS) begin
            wb_cyc <= 1'b1;
            wb_we  <= is_wr;
            to_cnt <= '0;
          end
        end
        S_WDATA: begin
          if (rx_stb) begin
            wb_wdata <= wdata_cat[DW-1:0];
            cnt      <= cnt + 1'b1;
          end
          if (state_d == S_BUS) begin
            wb_cyc <= 1'b1;
            wb_we  <= is_wr;
            to_cnt <= '0;
          end
        end
        S_BUS: begin
          // An ack on the terminal-count cycle still counts as success
          if (wb_ack) begin
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            status <= 8'h00;
            if (!is_wr) rdata_q <= wb_rdata;
          end else if (to_cnt == TO_LAST) begin
            wb_cyc <= 1'b0;
            wb_we  <= 1'b0;
            status <= 8'hEE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_STAT: cnt <= '0;
        S_RDATA: begin
          if (tx_ack) begin
            rdata_q <= rdata_q << 8;
            cnt     <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: host serial driver, Wishbone responder, TX byte
// decoder feeding a scoreboard queue, vector table plus hand-written sequences.
module tb_uart_wb_bridge;
  localparam int BIT_CYC = 5;              // uart_div = 4 -> 5 clocks per bit
  localparam int BIT_NS  = BIT_CYC * 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_line = 1'b1;
  logic        uart_tx;
  logic [7:0]  uart_div = 8'd4;
  logic [7:0]  wb_addr;
  logic [15:0] wb_wdata;
  logic [15:0] wb_rdata = '0;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack = 1'b0;
  logic        busy;
  logic        rx_drop;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_on;      // cycle of wb_cyc on which ack is raised, 0 = never
    logic        exp_we;
    int          exp_len;     // expected wb_cyc length in cycles
    logic [7:0]  exp_status;
  } vec_t;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic exp_drop = 1'b0;

  // responder bookkeeping
  int          ack_on = 0;
  int          pulses = 0;
  int          cyc_cnt = 0;
  int          last_len = 0;
  logic        cyc_prev = 1'b0;
  logic        unstable = 1'b0;
  logic [7:0]  seen_addr = '0;
  logic [15:0] seen_wdata = '0;
  logic        seen_we = 1'b0;

  uart_wb_bridge #(.DIV_WIDTH(8), .AW(8), .DW(16), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_line), .uart_tx(uart_tx), .uart_div(uart_div),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .busy(busy), .rx_drop(rx_drop)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Wishbone responder: samples on the falling edge, raises ack for cycle ack_on
  always @(negedge clk) begin
    if (wb_cyc) begin
      if (!cyc_prev) begin
        pulses++;
        cyc_cnt    = 0;
        seen_addr  = wb_addr;
        seen_we    = wb_we;
        seen_wdata = wb_wdata;
      end else if (wb_addr !== seen_addr || wb_we !== seen_we || wb_wdata !== seen_wdata) begin
        unstable = 1'b1;
      end
      cyc_cnt++;
      last_len = cyc_cnt;
      wb_ack = (ack_on != 0 && cyc_cnt == ack_on);
    end else begin
      wb_ack = 1'b0;
    end
    cyc_prev = wb_cyc;
  end

  // TX decoder: each received byte is compared against the head of exp_q
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      if (rst_n) begin
        #(BIT_NS / 2);
        b = '0;
        for (int i = 0; i < 8; i++) begin
          #(BIT_NS);
          b[i] = uart_tx;
        end
        #(BIT_NS);
        check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_extra: got byte %0h expected none", b);
        end else begin
          check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      repeat (BIT_CYC) @(negedge clk);
    end
  endtask

  task automatic vec_begin(input vec_t v);
    ack_on   = v.ack_on;
    wb_rdata = v.rdata;
    pulses   = 0;
    unstable = 1'b0;
    exp_q.push_back(v.exp_status);
    if (!v.exp_we && v.exp_status == 8'h00) begin
      exp_q.push_back(v.rdata[15:8]);
      exp_q.push_back(v.rdata[7:0]);
    end
  endtask

  task automatic vec_end(input vec_t v);
    int waited;
    waited = 0;
    while (busy && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("cyc_pulses", pulses, 1);
    check("cyc_len", last_len, v.exp_len);
    check("cyc_addr", {24'd0, seen_addr}, {24'd0, v.addr});
    check("cyc_we", {31'd0, seen_we}, {31'd0, v.exp_we});
    if (v.exp_we) check("cyc_wdata", {16'd0, seen_wdata}, {16'd0, v.wdata});
    check("cyc_stable", {31'd0, unstable}, 32'd0);
    check("cyc_low_after", {31'd0, wb_cyc}, 32'd0);
    check("rx_drop", {31'd0, rx_drop}, {31'd0, exp_drop});
    check("tx_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    vec_begin(v);
    send_byte(v.cmd);
    send_byte(v.addr);
    if (v.cmd == 8'h02) begin
      send_byte(v.wdata[15:8]);
      send_byte(v.wdata[7:0]);
    end
    vec_end(v);
  endtask

  // watchdog
  initial begin
    #(600_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   waited;
    logic saw_busy;

    //            cmd    addr   wdata     rdata     ack  we    len  status
    vecs[0] = '{8'h01, 8'h34, 16'h0000, 16'hBEEF,   2, 1'b0,   2, 8'h00};
    vecs[1] = '{8'h02, 8'h12, 16'hABCD, 16'h0000,   1, 1'b1,   1, 8'h00};
    vecs[2] = '{8'h01, 8'h55, 16'h0000, 16'h7777,   0, 1'b0, 255, 8'hEE};
    vecs[3] = '{8'h01, 8'h55, 16'h0000, 16'h1234, 255, 1'b0, 255, 8'h00};
    vecs[4] = '{8'h02, 8'hFF, 16'h0001, 16'h0000,   3, 1'b1,   3, 8'h00};
    vecs[5] = '{8'h02, 8'h80, 16'h5A5A, 16'h0000,   0, 1'b1, 255, 8'hEE};
    vecs[6] = '{8'h01, 8'h00, 16'h0000, 16'h8001,   1, 1'b0,   1, 8'h00};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_addr", {24'd0, wb_addr}, 32'd0);
    check("rst_wdata", {16'd0, wb_wdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {31'd0, rx_drop}, 32'd0);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // invalid command byte is ignored without touching busy or rx_drop
    saw_busy = 1'b0;
    send_byte(8'h7F);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("bad_cmd_busy", {31'd0, saw_busy}, 32'd0);
    run_vec('{8'h01, 8'h00, 16'h0000, 16'hC0DE, 1, 1'b0, 1, 8'h00});

    // extra byte while the responder stalls is dropped and flagged
    v = '{8'h01, 8'hC3, 16'h0000, 16'h4321, 200, 1'b0, 200, 8'h00};
    vec_begin(v);
    send_byte(v.cmd);
    send_byte(v.addr);
    waited = 0;
    while (!wb_cyc && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drop_cyc_seen", {31'd0, wb_cyc}, 32'd1);
    send_byte(8'h99);
    exp_drop = 1'b1;
    vec_end(v);
    run_vec('{8'h02, 8'h44, 16'h9876, 16'h0000, 2, 1'b1, 2, 8'h00});

    // reset in the middle of a stalled bus cycle
    ack_on = 0;
    send_byte(8'h01);
    send_byte(8'h66);
    waited = 0;
    while (!wb_cyc && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_cyc_seen", {31'd0, wb_cyc}, 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_addr", {24'd0, wb_addr}, 32'd0);
    check("arst_drop", {31'd0, rx_drop}, 32'd0);
    check("arst_tx", {31'd0, uart_tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_drop = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    run_vec('{8'h01, 8'h20, 16'h0000, 16'h5AA5, 1, 1'b0, 1, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
